lbm_step_scheduler: RTL and testbench
=====================================

// Module: lbm_step_scheduler
// PURPOSE
//  Sequences the LBM lattice datapath through whole timesteps: stream, bounce, zero and collide passes.
//  Each pass is a raster sweep of every cell. Start/done handshake to the host side.
//  Drives the cell address, column/row, edge flags and read/write strobes consumed by the direction RAMs.
//  Column/row come from counters, never from modulo or divide. Optional host-access window between steps.
// PARAMETERS
//  WIDTH   `WIDTH            lattice columns (>=2)
//  HEIGHT  `DEPTH/`WIDTH     lattice rows (>=2); DEPTH = WIDTH*HEIGHT
//  STEP_W  16                width of timestep count / request
// PORTS
//  clk         in   1                 single clock, all logic on posedge
//  rst         in   1                 synchronous, active-high reset
//  en          in   1                 run enable; low freezes all state, strobes forced 0
//  start       in   1                 1-cycle request to run num_steps timesteps; ignored while busy
//  num_steps   in   STEP_W            timesteps to run, sampled with start
//  busy        out  1                 high from cycle after accepted start until done
//  done        out  1                 1-cycle pulse when the run completes
//  phase       out  2                 lbm_pkg::phase_t: STREAM=0 BOUNCE=1 ZERO=2 COLLIDE=3
//  rd_stb      out  1                 read beat: RAMs read at cell_index
//  wr_stb      out  1                 write beat: datapath commits result for cell_index
//  cell_index  out  `ADDRESS_WIDTH    current cell, row-major
//  col / row   out  $clog2(WIDTH)/$clog2(HEIGHT)  coordinates of cell_index
//  at_n/at_s/at_w/at_e  out  1        row==0 / row==HEIGHT-1 / col==0 / col==WIDTH-1
//  step_count  out  STEP_W            completed timesteps in current run
//  host_req    in   1                 host wants lattice access (feature macro)
//  host_gnt    out  1                 host owns the RAMs; the scheduler issues no strobes
// BEHAVIOUR
//  - Reset: all outputs 0; FSM in IDLE; phase=STREAM; counters 0. rst mid-run aborts with no done pulse.
//  - FSM: IDLE -> RUN on start; RUN -> FINISH after last beat of last step; FINISH -> IDLE (done=1 here).
//  - HOST state exists only with the feature macro (see CONFIGURATION).
//  - start with num_steps==0: go straight to FINISH; done pulses 2 cycles after start; no strobes issued.
//  - Beat cadence in RUN:
//    - STREAM, BOUNCE, COLLIDE: RD beat (rd_stb=1), then WR beat (wr_stb=1), same cell_index.
//    - ZERO: single beat, wr_stb=1.
//  - Cell advance: after each WR beat; in ZERO, every cycle.
//    - col wraps WIDTH-1 -> 0 and increments row; row wraps HEIGHT-1 -> 0.
//    - cell_index increments with the cell and wraps DEPTH-1 -> 0.
//  - Phase advance: on wrap of the last cell; order STREAM -> BOUNCE -> ZERO -> COLLIDE -> STREAM.
//  - step_count increments on COLLIDE wrap. If the new value == num_steps, go to FINISH, else STREAM.
//  - Step length is exactly 7*DEPTH enabled cycles; cell_index/col/row/edge flags are valid on every strobe.
//  - en=0: registers hold; rd_stb=wr_stb=0. When en returns, the interrupted beat is reissued unchanged.
//  - busy falls in the FINISH cycle, concurrent with done.
//  - start during FINISH is ignored; start is accepted only in IDLE.
//  - step_count holds its final value until the next accepted start clears it.
// CONFIGURATION
//  - LBM_SCHED_HOST_ACCESS_EN defined:
//    - At each step boundary (COLLIDE wrap, not final step), if host_req=1 go to HOST, else continue at STREAM.
//    - In HOST: host_gnt=1, no strobes, counters held.
//    - On host_req=0: host_gnt drops next cycle and RUN resumes at STREAM, cell 0.
//    - host_req is ignored mid-pass and on the final step.
//  - LBM_SCHED_HOST_ACCESS_EN undefined: host_req ignored, host_gnt tied 0, no HOST state.
// STRUCTURE
//  - lbm_pkg holds phase_t, sched_state_t (IDLE/RUN/HOST/FINISH) and beat_t (RD/WR).
//    It also holds the CYCLES_PER_STEP=7*DEPTH constant.
//  - Sub-module lbm_cell_counter: col/row/index counters with inc, clear, wrap and edge-flag outputs.
//    It is instanced once here and is reusable by the datapath.
// TESTING (WIDTH=4, HEIGHT=3, DEPTH=12)
//  - start, num_steps=2 at cycle 0 -> busy cycles 1..168.
//    - Strobe count: 72 rd_stb, 96 wr_stb.
//    - done=1 only at cycle 169; step_count=2.
//  - Traversal check in STREAM -> cell_index 0..11 on WR beats, each index twice (RD then WR).
//    - col/row (3,0) at index 3; at_e=1 and at_n=1 at index 3; at_s=1 for indices 8..11.
//  - en=0 for cycles 10..14 of a num_steps=1 run -> no strobes in 10..14; done delayed to cycle 90.
//  - num_steps=0 -> done at cycle 2, busy never high, zero strobes.
//    - start re-pulsed while busy -> ignored, step_count unchanged.
//  - rst asserted at cycle 50 of a run -> cycle 51: all outputs 0, no done pulse.
//    - New start is accepted afterwards and its run is normal.
//  - With LBM_SCHED_HOST_ACCESS_EN, host_req=1 from cycle 40 to 100, num_steps=2:
//    - host_gnt=1 in cycles 85..100, no strobes in that window.
//    - Second step restarts at index 0; done at cycle 185.

Source files
------------

// File: rtl/lbm_pkg.sv
// Shared types and constants for the LBM timestep scheduler and its datapath.
//   phase_t         : pass currently being swept (STREAM, BOUNCE, ZERO, COLLIDE)
//   sched_state_t   : scheduler FSM states (IDLE, RUN, HOST, FINISH)
//   beat_t          : read or write beat within a two-beat pass
//   LBM_* / CYCLES_PER_STEP : default lattice geometry and enabled cycles per timestep
package lbm_pkg;

    localparam int LBM_WIDTH       = 4;
    localparam int LBM_HEIGHT      = 3;
    localparam int LBM_DEPTH       = LBM_WIDTH * LBM_HEIGHT;
    // Three two-beat passes plus one single-beat pass over every cell.
    localparam int CYCLES_PER_STEP = 7 * LBM_DEPTH;

    typedef enum logic [1:0] {
        STREAM  = 2'd0,
        BOUNCE  = 2'd1,
        ZERO    = 2'd2,
        COLLIDE = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HOST   = 2'd2,
        FINISH = 2'd3
    } sched_state_t;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } beat_t;

    // Pass order wraps COLLIDE -> STREAM through the 2-bit encoding.
    function automatic phase_t next_phase(input phase_t p);
        return phase_t'(p + 2'd1);
    endfunction

endpackage

// File: rtl/lbm_cell_counter.sv
// Raster cell counter for the LBM lattice: column, row and row-major index
// advance together, so coordinates never need a divide or modulo.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   inc               : advance to the next cell this cycle
//   clear             : return to cell 0 (wins over inc)
//   index / col / row : current cell and its coordinates
//   wrap              : inc is advancing past the last cell this cycle
//   at_n/at_s/at_w/at_e : row==0 / row==HEIGHT-1 / col==0 / col==WIDTH-1
module lbm_cell_counter #(
    parameter  int WIDTH  = 4,
    parameter  int HEIGHT = 3,
    localparam int DEPTH  = WIDTH * HEIGHT,
    localparam int COL_W  = $clog2(WIDTH),
    localparam int ROW_W  = $clog2(HEIGHT),
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              clear,
    output logic [ADDR_W-1:0] index,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic              wrap,
    output logic              at_n,
    output logic              at_s,
    output logic              at_w,
    output logic              at_e
);

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] index_reg;
    logic [COL_W-1:0]  col_reg;
    logic [ROW_W-1:0]  row_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            index_reg <= '0;
            col_reg   <= '0;
            row_reg   <= '0;
        end else if (inc) begin
            index_reg <= (index_reg == IDX_LAST) ? '0 : index_reg + 1'b1;
            if (col_reg == COL_LAST) begin
                col_reg <= '0;
                row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    assign index = index_reg;
    assign col   = col_reg;
    assign row   = row_reg;
    assign wrap  = inc && (index_reg == IDX_LAST);
    assign at_n  = (row_reg == '0);
    assign at_s  = (row_reg == ROW_LAST);
    assign at_w  = (col_reg == '0);
    assign at_e  = (col_reg == COL_LAST);

endmodule

// File: rtl/lbm_step_scheduler.sv
// Sequences the LBM datapath through whole timesteps. Each timestep is four
// raster passes (STREAM, BOUNCE, ZERO, COLLIDE); the two-beat passes issue a
// read then a write per cell, ZERO issues a single write per cell.
// Optional feature macro: LBM_SCHED_HOST_ACCESS_EN adds a HOST state at
// step boundaries in which the host owns the direction RAMs.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   en                   : run enable; low freezes everything and masks strobes
//   start, num_steps     : run request (accepted only in IDLE) and its length
//   busy, done           : run in progress / one-cycle completion pulse
//   phase                : current pass
//   rd_stb, wr_stb       : RAM read beat / datapath write beat for cell_index
//   cell_index, col, row : current cell, row-major, and its coordinates
//   at_n/at_s/at_w/at_e  : lattice edge flags (only asserted while running)
//   step_count           : timesteps completed in the current or last run
//   host_req, host_gnt   : host access request / grant between timesteps
module lbm_step_scheduler
    import lbm_pkg::*;
#(
    parameter  int WIDTH  = LBM_WIDTH,
    parameter  int HEIGHT = LBM_HEIGHT,
    parameter  int STEP_W = 16,
    localparam int DEPTH  = WIDTH * HEIGHT,
    localparam int COL_W  = $clog2(WIDTH),
    localparam int ROW_W  = $clog2(HEIGHT),
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic [STEP_W-1:0] num_steps,
    output logic              busy,
    output logic              done,
    output phase_t            phase,
    output logic              rd_stb,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] cell_index,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic              at_n,
    output logic              at_s,
    output logic              at_w,
    output logic              at_e,
    output logic [STEP_W-1:0] step_count,
    input  logic              host_req,
    output logic              host_gnt
);

    sched_state_t      state_reg, state_next;
    phase_t            phase_reg, phase_next;
    beat_t             beat_reg, beat_next;
    logic [STEP_W-1:0] step_count_reg, step_count_next;
    logic [STEP_W-1:0] num_steps_reg, num_steps_next;
    // Set for a zero-length run so FINISH lasts two cycles and done lands
    // two cycles after start.
    logic              zero_run_reg, zero_run_next;
    logic [STEP_W-1:0] step_inc;
    logic              cell_inc, cell_clear, cell_wrap;
    logic              rd_next, wr_next, done_next;
    logic              cnt_n, cnt_s, cnt_w, cnt_e;

    lbm_cell_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_cell (
        .clk   (clk),
        .rst   (rst),
        .inc   (cell_inc),
        .clear (cell_clear),
        .index (cell_index),
        .col   (col),
        .row   (row),
        .wrap  (cell_wrap),
        .at_n  (cnt_n),
        .at_s  (cnt_s),
        .at_w  (cnt_w),
        .at_e  (cnt_e)
    );

    assign step_inc = step_count_reg + STEP_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            phase_reg      <= STREAM;
            beat_reg       <= RD;
            step_count_reg <= '0;
            num_steps_reg  <= '0;
            zero_run_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            beat_reg       <= beat_next;
            step_count_reg <= step_count_next;
            num_steps_reg  <= num_steps_next;
            zero_run_reg   <= zero_run_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        phase_next      = phase_reg;
        beat_next       = beat_reg;
        step_count_next = step_count_reg;
        num_steps_next  = num_steps_reg;
        zero_run_next   = zero_run_reg;
        cell_inc        = 1'b0;
        cell_clear      = 1'b0;
        rd_next         = 1'b0;
        wr_next         = 1'b0;
        done_next       = 1'b0;
        if (en) begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        num_steps_next  = num_steps;
                        step_count_next = '0;
                        phase_next      = STREAM;
                        beat_next       = RD;
                        cell_clear      = 1'b1;
                        if (num_steps == '0) begin
                            state_next    = FINISH;
                            zero_run_next = 1'b1;
                        end else begin
                            state_next = RUN;
                        end
                    end
                end
                RUN: begin
                    if (phase_reg == ZERO) begin
                        wr_next  = 1'b1;
                        cell_inc = 1'b1;
                    end else if (beat_reg == RD) begin
                        rd_next   = 1'b1;
                        beat_next = WR;
                    end else begin
                        wr_next   = 1'b1;
                        cell_inc  = 1'b1;
                        beat_next = RD;
                    end
                    if (cell_wrap) begin
                        phase_next = next_phase(phase_reg);
                        if (phase_reg == COLLIDE) begin
                            step_count_next = step_inc;
                            if (step_inc == num_steps_reg) begin
                                state_next = FINISH;
                            end else begin
`ifdef LBM_SCHED_HOST_ACCESS_EN
                                if (host_req) state_next = HOST;
`endif
                            end
                        end
                    end
                end
                HOST: begin
`ifdef LBM_SCHED_HOST_ACCESS_EN
                    // Counters already sit at STREAM / cell 0 from the wrap.
                    if (!host_req) state_next = RUN;
`else
                    state_next = IDLE;
`endif
                end
                FINISH: begin
                    if (zero_run_reg) begin
                        zero_run_next = 1'b0;
                    end else begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign rd_stb     = rd_next;
    assign wr_stb     = wr_next;
    assign done       = done_next;
    assign busy       = (state_reg == RUN) || (state_reg == HOST);
    assign phase      = phase_reg;
    assign step_count = step_count_reg;
    assign at_n       = (state_reg == RUN) && cnt_n;
    assign at_s       = (state_reg == RUN) && cnt_s;
    assign at_w       = (state_reg == RUN) && cnt_w;
    assign at_e       = (state_reg == RUN) && cnt_e;

`ifdef LBM_SCHED_HOST_ACCESS_EN
    assign host_gnt = (state_reg == HOST);
`else
    logic unused_host_req;
    assign unused_host_req = host_req;
    assign host_gnt        = 1'b0;
`endif

endmodule

// File: tb/tb_lbm_step_scheduler.sv
// Directed bench for lbm_step_scheduler on a 4x3 lattice (DEPTH=12).
// Each scenario drives one input vector per cycle, records the outputs of
// that cycle, and the main sequence then checks recorded cycles against
// hand-computed values.
module tb_lbm_step_scheduler;

    localparam int N = 200;

    logic        clk;
    logic        rst;
    logic        en;
    logic        start;
    logic [15:0] num_steps;
    logic        busy;
    logic        done;
    logic [1:0]  phase;
    logic        rd_stb;
    logic        wr_stb;
    logic [3:0]  cell_index;
    logic [1:0]  col;
    logic [1:0]  row;
    logic        at_n, at_s, at_w, at_e;
    logic [15:0] step_count;
    logic        host_req;
    logic        host_gnt;

    int checks = 0;
    int errors = 0;

    bit rec_rd   [N];
    bit rec_wr   [N];
    bit rec_busy [N];
    bit rec_done [N];
    bit rec_gnt  [N];
    bit rec_n    [N];
    bit rec_s    [N];
    bit rec_w    [N];
    bit rec_e    [N];
    bit rec_any  [N];
    int rec_idx  [N];
    int rec_col  [N];
    int rec_row  [N];
    int rec_ph   [N];
    int rec_step [N];

    lbm_step_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .start      (start),
        .num_steps  (num_steps),
        .busy       (busy),
        .done       (done),
        .phase      (phase),
        .rd_stb     (rd_stb),
        .wr_stb     (wr_stb),
        .cell_index (cell_index),
        .col        (col),
        .row        (row),
        .at_n       (at_n),
        .at_s       (at_s),
        .at_w       (at_w),
        .at_e       (at_e),
        .step_count (step_count),
        .host_req   (host_req),
        .host_gnt   (host_gnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // sel: 0 rd, 1 wr, 2 busy, 3 done, 4 host_gnt; counts over cycles a..b
    function automatic int cnt(input int sel, input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) begin
            case (sel)
                0: n += int'(rec_rd[c]);
                1: n += int'(rec_wr[c]);
                2: n += int'(rec_busy[c]);
                3: n += int'(rec_done[c]);
                default: n += int'(rec_gnt[c]);
            endcase
        end
        return n;
    endfunction

    // Called at posedge+1: drive cycle c inputs, sample at +3, move to next cycle.
    task automatic run(input int ncyc, input int steps, input int s2a, input int s2b,
                       input int en_a, input int en_b, input int rst_at,
                       input int h_a, input int h_b);
        for (int c = 0; c < ncyc; c++) begin
            start     = (c == 0) || (c == s2a) || (c == s2b);
            num_steps = (c == 0) ? 16'(steps) : 16'd5;
            en        = !(c >= en_a && c <= en_b);
            rst       = (c == rst_at);
            host_req  = (c >= h_a && c <= h_b);
            #2;
            rec_rd[c]   = rd_stb;
            rec_wr[c]   = wr_stb;
            rec_busy[c] = busy;
            rec_done[c] = done;
            rec_gnt[c]  = host_gnt;
            rec_n[c]    = at_n;
            rec_s[c]    = at_s;
            rec_w[c]    = at_w;
            rec_e[c]    = at_e;
            rec_idx[c]  = int'(cell_index);
            rec_col[c]  = int'(col);
            rec_row[c]  = int'(row);
            rec_ph[c]   = int'(phase);
            rec_step[c] = int'(step_count);
            rec_any[c]  = |{busy, done, phase, rd_stb, wr_stb, cell_index, col, row,
                            at_n, at_s, at_w, at_e, step_count, host_gnt};
            @(posedge clk);
            #1;
        end
        start    = 1'b0;
        en       = 1'b1;
        rst      = 1'b0;
        host_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int bad_seq;
        int bad_edge;
        int k;
        rst       = 1'b1;
        en        = 1'b1;
        start     = 1'b0;
        num_steps = '0;
        host_req  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Two-step run: busy 1..168, done only at 169.
        run(175, 2, -1, -1, -1, -2, -1, -1, -2);
        check("reset_outputs_zero", int'(rec_any[0]), 0);
        check("a_busy_in_1_168", cnt(2, 1, 168), 168);
        check("a_busy_total", cnt(2, 0, 174), 168);
        check("a_rd_count", cnt(0, 0, 174), 72);
        check("a_wr_count", cnt(1, 0, 174), 96);
        check("a_done_at_169", int'(rec_done[169]), 1);
        check("a_done_count", cnt(3, 0, 174), 1);
        check("a_step_after_first", rec_step[85], 1);
        check("a_step_final", rec_step[172], 2);
        bad_seq  = 0;
        bad_edge = 0;
        for (int c = 1; c <= 24; c++) begin
            k = (c - 1) / 2;
            if (rec_rd[c] !== (c % 2 == 1) || rec_wr[c] !== (c % 2 == 0) || rec_idx[c] != k)
                bad_seq++;
            if (rec_col[c] != k % 4 || rec_row[c] != k / 4 ||
                rec_n[c] !== (k / 4 == 0) || rec_s[c] !== (k / 4 == 2) ||
                rec_w[c] !== (k % 4 == 0) || rec_e[c] !== (k % 4 == 3))
                bad_edge++;
        end
        check("a_stream_traversal", bad_seq, 0);
        check("a_stream_coords_edges", bad_edge, 0);
        check("a_idx3_col", rec_col[8], 3);
        check("a_idx3_row", rec_row[8], 0);
        check("a_idx3_at_e", int'(rec_e[8]), 1);
        check("a_idx3_at_n", int'(rec_n[8]), 1);
        check("a_idx8_at_s", int'(rec_s[18]), 1);
        check("a_phase_bounce", rec_ph[25], 1);
        check("a_phase_zero", rec_ph[49], 2);
        check("a_phase_collide", rec_ph[61], 3);
        check("a_zero_wr", cnt(1, 49, 60), 12);
        check("a_zero_rd", cnt(0, 49, 60), 0);
        check("a_step2_restart_idx", rec_idx[85], 0);
        check("a_step2_restart_phase", rec_ph[85], 0);

        // One-step run with en low in cycles 10..14.
        do_reset();
        run(95, 1, -1, -1, 10, 14, -1, -1, -2);
        check("b_no_strobe_en_low", cnt(0, 10, 14) + cnt(1, 10, 14), 0);
        check("b_reissue_wr", int'(rec_wr[15]), 1);
        check("b_reissue_idx", rec_idx[15], 4);
        check("b_done_not_85", int'(rec_done[85]), 0);
        check("b_done_at_90", int'(rec_done[90]), 1);
        check("b_done_count", cnt(3, 0, 94), 1);
        check("b_rd_count", cnt(0, 0, 94), 36);
        check("b_wr_count", cnt(1, 0, 94), 48);

        // Zero-step run.
        do_reset();
        run(6, 0, -1, -1, -1, -2, -1, -1, -2);
        check("c_done_at_2", int'(rec_done[2]), 1);
        check("c_done_count", cnt(3, 0, 5), 1);
        check("c_busy_never", cnt(2, 0, 5), 0);
        check("c_no_strobes", cnt(0, 0, 5) + cnt(1, 0, 5), 0);

        // Start re-pulsed while busy and during FINISH: both ignored.
        do_reset();
        run(95, 1, 30, 85, -1, -2, -1, -1, -2);
        check("d_done_at_85", int'(rec_done[85]), 1);
        check("d_done_count", cnt(3, 0, 94), 1);
        check("d_busy_count", cnt(2, 0, 94), 84);
        check("d_step_final", rec_step[90], 1);

        // Reset mid-run, then a fresh normal run.
        do_reset();
        run(60, 2, -1, -1, -1, -2, 50, -1, -2);
        check("e_outputs_zero_51", int'(rec_any[51]), 0);
        check("e_no_done", cnt(3, 0, 59), 0);
        run(90, 1, -1, -1, -1, -2, -1, -1, -2);
        check("e_rerun_done_85", int'(rec_done[85]), 1);
        check("e_rerun_rd", cnt(0, 0, 89), 36);
        check("e_rerun_wr", cnt(1, 0, 89), 48);

        // Host request held across the first step boundary.
        do_reset();
        run(190, 2, -1, -1, -1, -2, -1, 40, 99);
`ifdef LBM_SCHED_HOST_ACCESS_EN
        check("f_gnt_window", cnt(4, 85, 100), 16);
        check("f_gnt_total", cnt(4, 0, 189), 16);
        check("f_no_strobe_gnt", cnt(0, 85, 100) + cnt(1, 85, 100), 0);
        check("f_resume_rd", int'(rec_rd[101]), 1);
        check("f_resume_idx", rec_idx[101], 0);
        check("f_resume_phase", rec_ph[101], 0);
        check("f_done_at_185", int'(rec_done[185]), 1);
        check("f_done_count", cnt(3, 0, 189), 1);
`else
        check("f_gnt_never", cnt(4, 0, 189), 0);
        check("f_done_at_169", int'(rec_done[169]), 1);
        check("f_done_count", cnt(3, 0, 189), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
